// File: rtl/oled_pixel_streamer.sv
// Streams one RGB565 frame as 9-bit {DC, byte} words: a command header, then hi/lo bytes per pixel.
// Define OLED_WINDOW_CMD_EN to prepend the column/row window commands to the header.
module oled_pixel_streamer #(
  parameter int WIDTH  = 128,
  parameter int HEIGHT = 128
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        frame_start_i,
  input  logic [15:0] pix_data_i,
  input  logic        pix_valid_i,
  output logic        pix_ready_o,
  output logic [8:0]  word_data_o,
  output logic        word_valid_o,
  input  logic        word_ready_i,
  output logic        busy_o,
  output logic        frame_done_o
);
  typedef enum logic [2:0] {IDLE, CMD, PIX_FETCH, PIX_HI, PIX_LO, DONE} state_t;

  localparam logic [14:0] LAST_PIX = 15'(WIDTH * HEIGHT - 1);

  state_t      state_q, state_d;
  logic [14:0] cnt_q, cnt_d;
  logic [15:0] pix_q, pix_d;
  logic        word_xfer, pix_xfer, hdr_last;
  logic [8:0]  hdr_word;

`ifdef OLED_WINDOW_CMD_EN
  logic [2:0] hdr_idx_q, hdr_idx_d;

  assign hdr_last = (hdr_idx_q == 3'd6);

  always_comb begin
    case (hdr_idx_q)
      3'd0:    hdr_word = 9'h015;
      3'd1:    hdr_word = 9'h100;
      3'd2:    hdr_word = {1'b1, 8'(WIDTH - 1)};
      3'd3:    hdr_word = 9'h075;
      3'd4:    hdr_word = 9'h100;
      3'd5:    hdr_word = {1'b1, 8'(HEIGHT - 1)};
      default: hdr_word = 9'h05C;
    endcase
  end

  always_comb begin
    hdr_idx_d = hdr_idx_q;
    if (state_q == IDLE)
      hdr_idx_d = 3'd0;
    else if (state_q == CMD && word_xfer)
      hdr_idx_d = hdr_last ? 3'd0 : hdr_idx_q + 3'd1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) hdr_idx_q <= 3'd0;
    else       hdr_idx_q <= hdr_idx_d;
  end
`else
  assign hdr_last = 1'b1;
  assign hdr_word = 9'h05C;
`endif

  // All handshake outputs decode registered state only, so no ready/valid combinational paths exist.
  assign pix_ready_o  = (state_q == PIX_FETCH);
  assign word_valid_o = (state_q == CMD) || (state_q == PIX_HI) || (state_q == PIX_LO);
  assign busy_o       = (state_q != IDLE) && (state_q != DONE);
  assign frame_done_o = (state_q == DONE);
  assign word_xfer    = word_valid_o & word_ready_i;
  assign pix_xfer     = pix_ready_o & pix_valid_i;

  always_comb begin
    word_data_o = 9'h000;
    case (state_q)
      CMD:     word_data_o = hdr_word;
      PIX_HI:  word_data_o = {1'b1, pix_q[15:8]};
      PIX_LO:  word_data_o = {1'b1, pix_q[7:0]};
      default: word_data_o = 9'h000;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pix_d   = pix_q;
    case (state_q)
      IDLE: begin
        if (frame_start_i) begin
          state_d = CMD;
          cnt_d   = 15'd0;
        end
      end
      CMD: begin
        if (word_xfer && hdr_last) state_d = PIX_FETCH;
      end
      PIX_FETCH: begin
        if (pix_xfer) begin
          pix_d   = pix_data_i;
          state_d = PIX_HI;
        end
      end
      PIX_HI: begin
        if (word_xfer) state_d = PIX_LO;
      end
      PIX_LO: begin
        if (word_xfer) begin
          cnt_d   = cnt_q + 15'd1;
          state_d = (cnt_q == LAST_PIX) ? DONE : PIX_FETCH;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= 15'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Pixel holding register is pure data; outputs mask it outside PIX_HI/PIX_LO.
  always_ff @(posedge clk_i) begin
    pix_q <= pix_d;
  end
endmodule

// File: doc/oled_pixel_streamer.md
OLED_PIXEL_STREAMER -- requirements
Module: oled_pixel_streamer

Interface
REQ-001 Parameter WIDTH, default 128, active columns per frame (1..128).
REQ-002 Parameter HEIGHT, default 128, active rows per frame (1..128).
REQ-003 CLK  in  1  sole clock; all state changes on rising edge.
REQ-004 RST  in  1  reset, asynchronous, active-high.
REQ-005 FRAME_START  in  1  one-cycle request to stream one frame.
REQ-006 PIX_DATA  in  16  RGB565 pixel, [15:8] sent first.
REQ-007 PIX_VALID  in  1  PIX_DATA valid.
REQ-008 PIX_READY  out  1  streamer accepts pixel this cycle.
REQ-009 WORD_DATA  out  9  {DCb, byte} to SPI serializer stage; bit 8 = 0 command, 1 data.
REQ-010 WORD_VALID  out  1  WORD_DATA valid.
REQ-011 WORD_READY  in  1  serializer accepts word this cycle.
REQ-012 BUSY  out  1  high from FRAME_START acceptance until FRAME_DONE.
REQ-013 FRAME_DONE  out  1  one-cycle pulse after last pixel byte accepted.

Function
REQ-014 Pixel transfer SHALL occur on a cycle with PIX_VALID and PIX_READY both high; word transfer on a cycle with WORD_VALID and WORD_READY both high.
REQ-015 Once WORD_VALID is high, WORD_DATA SHALL stay constant and WORD_VALID high until transfer.
REQ-016 WORD_VALID SHALL not depend combinationally on WORD_READY; PIX_READY SHALL not depend combinationally on PIX_VALID.
REQ-017 States: IDLE, CMD (header word sequence), PIX_FETCH, PIX_HI, PIX_LO, DONE.
REQ-018 IDLE: FRAME_START high -> CMD next cycle, BUSY high, pixel counter cleared; FRAME_START in any other state SHALL be ignored.
REQ-019 CMD: emit header words in order, each held until transferred; after final header word (0x05C) transfers -> PIX_FETCH.
REQ-020 PIX_FETCH: PIX_READY high; on pixel transfer latch PIX_DATA, -> PIX_HI; PIX_READY low in all other states.
REQ-021 PIX_HI: present {1, pix[15:8]}; on transfer -> PIX_LO.
REQ-022 PIX_LO: present {1, pix[7:0]}; on transfer increment 15-bit pixel counter; counter = WIDTH*HEIGHT-1 before increment -> DONE, else -> PIX_FETCH.
REQ-023 DONE: FRAME_DONE high exactly one cycle, BUSY low same cycle, -> IDLE.
REQ-024 Minimum spacing: new word presented cycle after previous transfer; pixel accepted cycle after low byte transfers (no pixel prefetch).
REQ-025 Stalls of either handshake of any length SHALL cause no loss, duplication or reordering of words.
REQ-026 Pixel counter SHALL never wrap within a frame; cleared on each accepted FRAME_START.

Reset
REQ-027 RST high SHALL force immediately: state IDLE, WORD_VALID 0, WORD_DATA 0x000, PIX_READY 0, BUSY 0, FRAME_DONE 0, counter 0, header index 0.
REQ-028 RST mid-frame SHALL abandon frame with no FRAME_DONE; after release, next FRAME_START begins full header.
REQ-029 After RST deasserts, no output SHALL change until FRAME_START.

Configuration
REQ-030 Macro OLED_WINDOW_CMD_EN defined: header = 0x015, 0x100, {1, WIDTH-1}, 0x075, 0x100, {1, HEIGHT-1}, 0x05C (7 words).
REQ-031 Macro OLED_WINDOW_CMD_EN undefined: header = 0x05C only (1 word); window logic absent.

Verification
REQ-032 WIDTH=4, HEIGHT=2, macro defined, WORD_READY=1, PIX_VALID=1, pixels 0x1234,0x5678,...: FRAME_START -> words 015,100,103,075,100,101,05C,112,134,156,178,... 16 data words, then one FRAME_DONE pulse.
REQ-033 Same, macro undefined -> first word 05C followed directly by 112,134.
REQ-034 WORD_READY random 30% duty, PIX_VALID random 50% -> word stream identical to REQ-032, WORD_DATA stable during every stall.
REQ-035 FRAME_START pulsed again during PIX_HI -> ignored; exactly 8 pixels consumed, one FRAME_DONE.
REQ-036 RST asserted after 3rd pixel accepted -> WORD_VALID and BUSY 0 same cycle, no FRAME_DONE; new FRAME_START restarts with 015 (macro defined).
REQ-037 WIDTH=128, HEIGHT=128 -> exactly 16384 pixels accepted, 32768 data words, FRAME_DONE one cycle after last transfer.
